// File: rtl/axi_adder_pkg.sv
// Shared constants for the two-operand stream adder.
// Build option: AXI_ADDER_STATS_EN adds sum_count / overflow_seen.
package axi_adder_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SUM_W  = 16;
  localparam int CARRY_BIT  = DEF_DATA_W;
  localparam int CNT_W      = 16;
endpackage

// File: rtl/axis_operand_slot.sv
// One-deep operand buffer: holding register, full flag, ready.
// Ready stays open when the held operand is consumed this edge.
module axis_operand_slot
  import axi_adder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              clear_on_fire,
  output logic [DATA_W-1:0] data,
  output logic              full
);

  // Accept when empty or when the held value leaves this edge
  always_comb begin
    s_ready = !rst && (!full || clear_on_fire);
  end

  // Capture wins over clear so a same-edge refill stays full
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (s_valid && s_ready) begin
      full <= 1'b1;
      data <= s_data;
    end else if (clear_on_fire) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_8bit_adder.sv
// Pairs operands from two streams in order and emits their sum.
// Build option: AXI_ADDER_STATS_EN adds sum_count / overflow_seen.
module axis_8bit_adder
  import axi_adder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SUM_W  = DEF_SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_data1,
  input  logic              s_axis_valid1,
  output logic              s_axis_ready1,
  input  logic [DATA_W-1:0] s_axis_data2,
  input  logic              s_axis_valid2,
  output logic              s_axis_ready2,
  output logic [SUM_W-1:0]  m_axis_data,
  output logic              m_axis_valid,
`ifdef AXI_ADDER_STATS_EN
  output logic [CNT_W-1:0]  sum_count,
  output logic              overflow_seen,
`endif
  input  logic              m_axis_ready
);

  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              a_full;
  logic              b_full;
  logic              fire;
  logic [DATA_W:0]   sum_w;

  axis_operand_slot #(.DATA_W(DATA_W)) u_slot_a (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_axis_data1),
    .s_valid       (s_axis_valid1),
    .s_ready       (s_axis_ready1),
    .clear_on_fire (fire),
    .data          (a_data),
    .full          (a_full)
  );

  axis_operand_slot #(.DATA_W(DATA_W)) u_slot_b (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_axis_data2),
    .s_valid       (s_axis_valid2),
    .s_ready       (s_axis_ready2),
    .clear_on_fire (fire),
    .data          (b_data),
    .full          (b_full)
  );

  // Fire when both operands wait and the output can take a result
  always_comb begin
    fire  = a_full && b_full && (!m_axis_valid || m_axis_ready);
    sum_w = {1'b0, a_data} + {1'b0, b_data};
  end

  // Output register: load on fire, drop valid once consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
    end else if (fire) begin
      m_axis_valid <= 1'b1;
      m_axis_data  <= SUM_W'(sum_w);
    end else if (m_axis_valid && m_axis_ready) begin
      m_axis_valid <= 1'b0;
    end
  end

`ifdef AXI_ADDER_STATS_EN
  // Count output handshakes; flag any sum carrying out of DATA_W
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_count     <= '0;
      overflow_seen <= 1'b0;
    end else begin
      if (m_axis_valid && m_axis_ready)
        sum_count <= sum_count + 1'b1;
      if (fire && sum_w[DATA_W])
        overflow_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_8bit_adder.sv
// Directed bench for axis_8bit_adder.
// Vector table plus skew, backpressure, streaming and reset cases.
module tb_axis_8bit_adder;

  logic        clk;
  logic        rst;
  logic [7:0]  s_axis_data1;
  logic        s_axis_valid1;
  logic        s_axis_ready1;
  logic [7:0]  s_axis_data2;
  logic        s_axis_valid2;
  logic        s_axis_ready2;
  logic [15:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready;
`ifdef AXI_ADDER_STATS_EN
  logic [15:0] sum_count;
  logic        overflow_seen;
`endif

  int n_pass;
  int n_total;

  axis_8bit_adder dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_data1  (s_axis_data1),
    .s_axis_valid1 (s_axis_valid1),
    .s_axis_ready1 (s_axis_ready1),
    .s_axis_data2  (s_axis_data2),
    .s_axis_valid2 (s_axis_valid2),
    .s_axis_ready2 (s_axis_ready2),
    .m_axis_data   (m_axis_data),
    .m_axis_valid  (m_axis_valid),
`ifdef AXI_ADDER_STATS_EN
    .sum_count     (sum_count),
    .overflow_seen (overflow_seen),
`endif
    .m_axis_ready  (m_axis_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] sum;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic va, input logic [7:0] a,
                       input logic vb, input logic [7:0] b);
    s_axis_valid1 = va;
    s_axis_data1  = a;
    s_axis_valid2 = vb;
    s_axis_data2  = b;
  endtask

  initial begin
    logic [15:0] exp_s[4];
    int idx;
    int first_c;
    int last_c;

    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{8'h05, 8'h03, 16'h0008};
    vecs[1] = '{8'hFF, 8'hFF, 16'h01FE};
    vecs[2] = '{8'h00, 8'h00, 16'h0000};
    vecs[3] = '{8'h80, 8'h80, 16'h0100};
    vecs[4] = '{8'h7F, 8'h01, 16'h0080};
    vecs[5] = '{8'h01, 8'hFE, 16'h00FF};

    rst = 1'b1;
    m_axis_ready = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    step();
    chk("rst_ready1", 32'(s_axis_ready1), 32'd0);
    chk("rst_ready2", 32'(s_axis_ready2), 32'd0);
    chk("rst_valid", 32'(m_axis_valid), 32'd0);
    chk("rst_data", 32'(m_axis_data), 32'd0);
`ifdef AXI_ADDER_STATS_EN
    chk("rst_count", 32'(sum_count), 32'd0);
    chk("rst_ovf", 32'(overflow_seen), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_ready1", 32'(s_axis_ready1), 32'd1);
    chk("post_rst_ready2", 32'(s_axis_ready2), 32'd1);

    // table: handshake, sum one edge later, consumed the edge after
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].a, 1'b1, vecs[i].b);
      step();
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      chk("vec_lat_valid0", 32'(m_axis_valid), 32'd0);
      step();
      chk("vec_valid", 32'(m_axis_valid), 32'd1);
      chk("vec_sum", 32'(m_axis_data), 32'(vecs[i].sum));
      step();
      chk("vec_consumed", 32'(m_axis_valid), 32'd0);
      chk("vec_hold_data", 32'(m_axis_data), 32'(vecs[i].sum));
    end
`ifdef AXI_ADDER_STATS_EN
    chk("ovf_seen", 32'(overflow_seen), 32'd1);
`endif

    // skew: A three cycles ahead of B
    drive(1'b1, 8'h10, 1'b0, 8'h00);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("skew_ready1_low", 32'(s_axis_ready1), 32'd0);
    step();
    step();
    chk("skew_ready1_still", 32'(s_axis_ready1), 32'd0);
    chk("skew_no_out", 32'(m_axis_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 8'h20);
    #1;
    chk("skew_ready2", 32'(s_axis_ready2), 32'd1);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("skew_pre_valid", 32'(m_axis_valid), 32'd0);
    step();
    chk("skew_valid", 32'(m_axis_valid), 32'd1);
    chk("skew_sum", 32'(m_axis_data), 32'h30);
    step();
    chk("skew_once", 32'(m_axis_valid), 32'd0);
    step();
    chk("skew_no_extra", 32'(m_axis_valid), 32'd0);

    // backpressure: pending 7, slots hold 5/6, 8/9 waits at the ports
    m_axis_ready = 1'b0;
    drive(1'b1, 8'd3, 1'b1, 8'd4);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    chk("bp_valid", 32'(m_axis_valid), 32'd1);
    chk("bp_sum", 32'(m_axis_data), 32'd7);
    drive(1'b1, 8'd5, 1'b1, 8'd6);
    step();
    drive(1'b1, 8'd8, 1'b1, 8'd9);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", 32'(m_axis_valid), 32'd1);
      chk("bp_hold_data", 32'(m_axis_data), 32'd7);
      chk("bp_ready1_low", 32'(s_axis_ready1), 32'd0);
      chk("bp_ready2_low", 32'(s_axis_ready2), 32'd0);
      step();
    end
    m_axis_ready = 1'b1;
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("bp_second", 32'(m_axis_data), 32'd11);
    chk("bp_second_v", 32'(m_axis_valid), 32'd1);
    step();
    chk("bp_third", 32'(m_axis_data), 32'd17);
    chk("bp_third_v", 32'(m_axis_valid), 32'd1);
    step();
    chk("bp_drain", 32'(m_axis_valid), 32'd0);

    // back-to-back stream
    exp_s[0] = 16'd11;
    exp_s[1] = 16'd22;
    exp_s[2] = 16'd33;
    exp_s[3] = 16'd44;
    idx = 0;
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, 8'(c + 1), 1'b1, 8'((c + 1) * 10));
      else drive(1'b0, 8'h00, 1'b0, 8'h00);
      step();
      if (m_axis_valid) begin
        if (idx < 4) chk("b2b_sum", 32'(m_axis_data), 32'(exp_s[idx]));
        if (first_c < 0) first_c = c;
        last_c = c;
        idx++;
      end
    end
    chk("b2b_count", 32'(idx), 32'd4);
    chk("b2b_span", 32'(last_c - first_c), 32'd3);
`ifdef AXI_ADDER_STATS_EN
    chk("stats_count", 32'(sum_count), 32'd14);
`endif

    // reset with a pending sum and a held operand
    m_axis_ready = 1'b0;
    drive(1'b1, 8'd2, 1'b1, 8'd2);
    step();
    drive(1'b1, 8'd7, 1'b0, 8'h00);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("mr_pending", 32'(m_axis_valid), 32'd1);
    chk("mr_a_held", 32'(s_axis_ready1), 32'd0);
    rst = 1'b1;
    #1;
    chk("mr_rst_ready1", 32'(s_axis_ready1), 32'd0);
    chk("mr_rst_ready2", 32'(s_axis_ready2), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(m_axis_valid), 32'd0);
    chk("mr_data", 32'(m_axis_data), 32'd0);
    chk("mr_ready1", 32'(s_axis_ready1), 32'd1);
    chk("mr_ready2", 32'(s_axis_ready2), 32'd1);
`ifdef AXI_ADDER_STATS_EN
    chk("mr_count", 32'(sum_count), 32'd0);
    chk("mr_ovf", 32'(overflow_seen), 32'd0);
`endif
    m_axis_ready = 1'b1;
    drive(1'b1, 8'd1, 1'b1, 8'd1);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("mr_no_stale", 32'(m_axis_valid), 32'd0);
    step();
    chk("mr_new_valid", 32'(m_axis_valid), 32'd1);
    chk("mr_new_sum", 32'(m_axis_data), 32'd2);
    step();
    chk("mr_new_done", 32'(m_axis_valid), 32'd0);
    step();
    chk("mr_no_extra", 32'(m_axis_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
